// File: rtl/imem_port_arbiter_if.sv
// Bundle of fetch (F), loader (L) and instruction-memory signals shared by imem_port_arbiter.
// Define IMEM_BOUNDS_CHECK_EN to add the f_err / l_err response flags.
interface imem_port_arbiter_if;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;

  logic        l_req;
  logic        l_we;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_rvalid;
  logic [31:0] l_rdata;

  logic [31:0] mem_a;
  logic        mem_we;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

`ifdef IMEM_BOUNDS_CHECK_EN
  logic        f_err;
  logic        l_err;
`endif

  // Arbiter side.
  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rd,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_a, mem_we, mem_wd
`ifdef IMEM_BOUNDS_CHECK_EN
    , output f_err, l_err
`endif
  );

  // Requester/memory side.
  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, mem_rd,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           mem_a, mem_we, mem_wd
`ifdef IMEM_BOUNDS_CHECK_EN
    , input f_err, l_err
`endif
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Two-requester arbiter for the instruction-memory port: fetch wins ties, loader is forced
// through after MAX_BURST fetch grants. Optional IMEM_BOUNDS_CHECK_EN adds address checking.
module imem_port_arbiter #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned MAX_BURST = 4
) (
  input logic               clk,
  input logic               rst_n,
  imem_port_arbiter_if.slave bus
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [31:0]   BAD_DATA  = 32'hDEAD_BEEF;

  if (MAX_BURST < 1 || DEPTH < 1) begin : g_param_check
    $error("imem_port_arbiter: DEPTH and MAX_BURST must be >= 1");
  end

  typedef enum logic [1:0] {GNT_NONE, GNT_F, GNT_L} gnt_e;

  gnt_e          gnt;
  logic [BW-1:0] burst_q, burst_d;
  logic          f_rvalid_q, f_rvalid_d;
  logic [31:0]   f_rdata_q, f_rdata_d;
  logic          l_rvalid_q, l_rvalid_d;
  logic [31:0]   l_rdata_q, l_rdata_d;
  logic          f_err_q, f_err_d;
  logic          l_err_q, l_err_d;
  logic          f_bad, l_bad;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);
  assign f_bad = (bus.f_addr[1:0] != 2'b00) || (bus.f_addr >= ADDR_LIMIT);
  assign l_bad = (bus.l_addr[1:0] != 2'b00) || (bus.l_addr >= ADDR_LIMIT);
  assign bus.f_err = f_err_q;
  assign bus.l_err = l_err_q;
`else
  assign f_bad = 1'b0;
  assign l_bad = 1'b0;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    gnt         = GNT_NONE;
    burst_d     = burst_q;
    bus.mem_a   = '0;
    bus.mem_we  = 1'b0;
    bus.mem_wd  = '0;
    f_rvalid_d  = 1'b0;
    f_rdata_d   = f_rdata_q;
    f_err_d     = 1'b0;
    l_rvalid_d  = 1'b0;
    l_rdata_d   = l_rdata_q;
    l_err_d     = 1'b0;

    // Grants are suppressed while reset is held so every output reads 0.
    if (rst_n) begin
      if (bus.l_req && (!bus.f_req || burst_q == BURST_MAX)) gnt = GNT_L;
      else if (bus.f_req)                                    gnt = GNT_F;
    end

    if (!bus.l_req || gnt == GNT_L)                 burst_d = '0;
    else if (gnt == GNT_F && burst_q != BURST_MAX)  burst_d = burst_q + 1'b1;

    unique case (gnt)
      GNT_F: begin
        bus.mem_a  = bus.f_addr & ~32'h3;
        f_rvalid_d = 1'b1;
        f_rdata_d  = f_bad ? BAD_DATA : bus.mem_rd;
        f_err_d    = f_bad;
      end
      GNT_L: begin
        bus.mem_a  = bus.l_addr & ~32'h3;
        bus.mem_we = bus.l_we && !l_bad;
        bus.mem_wd = bus.l_wdata;
        l_rvalid_d = 1'b1;
        l_rdata_d  = l_bad ? BAD_DATA : (bus.l_we ? 32'h0 : bus.mem_rd);
        l_err_d    = l_bad;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_q    <= '0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      f_err_q    <= 1'b0;
      l_rvalid_q <= 1'b0;
      l_rdata_q  <= '0;
      l_err_q    <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      f_rvalid_q <= f_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      f_err_q    <= f_err_d;
      l_rvalid_q <= l_rvalid_d;
      l_rdata_q  <= l_rdata_d;
      l_err_q    <= l_err_d;
    end
  end

  assign bus.f_gnt    = (gnt == GNT_F);
  assign bus.l_gnt    = (gnt == GNT_L);
  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_rdata  = l_rdata_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a 64-word behavioural memory preloaded with
// 0x1000_0000 + index; the bounds scenario runs only when IMEM_BOUNDS_CHECK_EN is defined.
module tb_imem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [31:0] mem [64];

  imem_port_arbiter_if bus ();

  imem_port_arbiter #(.DEPTH(64), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.f_req = 1'b0; bus.l_req = 1'b0; bus.l_we = 1'b0;
  endtask

  task automatic test_reset;
    bus.f_req = 1'b1; bus.f_addr = 32'h4;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h8; bus.l_wdata = 32'hFFFF_FFFF;
    tick();
    n_cmp++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !== {1'b0, 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset_grant_mem: got %h expected %h",
               {bus.f_gnt, bus.l_gnt, bus.mem_we, bus.mem_a, bus.mem_wd}, 67'h0);
    end
    n_cmp++;
    if ({bus.f_rvalid, bus.f_rdata, bus.l_rvalid, bus.l_rdata} !== 66'h0) begin
      n_bad++;
      $display("FAIL reset_resp: got %h expected %h",
               {bus.f_rvalid, bus.f_rdata, bus.l_rvalid, bus.l_rdata}, 66'h0);
    end
    idle();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_f_stream;
    bus.l_req = 1'b0;
    bus.f_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.f_addr = 32'(i * 4);
      #1;
      n_cmp++;
      if ({bus.f_gnt, bus.l_gnt, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 1'b0, 32'(i * 4)}) begin
        n_bad++;
        $display("FAIL f_stream_gnt[%0d]: got %h expected %h", i,
                 {bus.f_gnt, bus.l_gnt, bus.mem_we, bus.mem_a}, {1'b1, 1'b0, 1'b0, 32'(i * 4)});
      end
      if (i > 0) begin
        n_cmp++;
        if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'h1000_0000 + 32'(i - 1)}) begin
          n_bad++;
          $display("FAIL f_stream_resp[%0d]: got %h expected %h", i,
                   {bus.f_rvalid, bus.f_rdata}, {1'b1, 32'h1000_0000 + 32'(i - 1)});
        end
      end
      tick();
    end
    bus.f_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.f_gnt, bus.f_rvalid, bus.f_rdata} !== {1'b0, 1'b1, 32'h1000_0002}) begin
      n_bad++;
      $display("FAIL f_stream_last: got %h expected %h",
               {bus.f_gnt, bus.f_rvalid, bus.f_rdata}, {1'b0, 1'b1, 32'h1000_0002});
    end
    tick();
    n_cmp++;
    if (bus.f_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL f_stream_idle_rvalid: got %b expected 0", bus.f_rvalid);
    end
  endtask

  task automatic test_l_write_read;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h28; bus.l_wdata = 32'hE3A0_B005;
    #1;
    n_cmp++;
    if ({bus.l_gnt, bus.f_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !==
        {1'b1, 1'b0, 1'b1, 32'h28, 32'hE3A0_B005}) begin
      n_bad++;
      $display("FAIL l_write_drive: got %h expected %h",
               {bus.l_gnt, bus.f_gnt, bus.mem_we, bus.mem_a, bus.mem_wd},
               {1'b1, 1'b0, 1'b1, 32'h28, 32'hE3A0_B005});
    end
    tick();
    bus.l_we = 1'b0;
    #1;
    n_cmp++;
    if ({bus.l_rvalid, bus.l_rdata} !== {1'b1, 32'h0}) begin
      n_bad++;
      $display("FAIL l_write_ack: got %h expected %h", {bus.l_rvalid, bus.l_rdata}, {1'b1, 32'h0});
    end
    n_cmp++;
    if ({bus.l_gnt, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 32'h28}) begin
      n_bad++;
      $display("FAIL l_read_b2b_gnt: got %h expected %h",
               {bus.l_gnt, bus.mem_we, bus.mem_a}, {1'b1, 1'b0, 32'h28});
    end
    tick();
    bus.l_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.l_rvalid, bus.l_rdata} !== {1'b1, 32'hE3A0_B005}) begin
      n_bad++;
      $display("FAIL l_read_data: got %h expected %h", {bus.l_rvalid, bus.l_rdata}, {1'b1, 32'hE3A0_B005});
    end
    tick();
    n_cmp++;
    if (bus.l_rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL l_idle_rvalid: got %b expected 0", bus.l_rvalid);
    end
  endtask

  task automatic test_arbitration;
    logic [9:0] exp_l;
    logic       prev_l, prev_f, e;
    exp_l  = 10'b10_0001_0000;
    prev_l = 1'b0;
    prev_f = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'hC;
    bus.l_req = 1'b1; bus.l_we = 1'b0; bus.l_addr = 32'h8;
    for (int i = 0; i < 10; i++) begin
      e = exp_l[i];
      #1;
      n_cmp++;
      if ({bus.f_gnt, bus.l_gnt} !== {~e, e}) begin
        n_bad++;
        $display("FAIL arb_gnt[%0d]: got f/l %b%b expected %b%b", i, bus.f_gnt, bus.l_gnt, ~e, e);
      end
      n_cmp++;
      if ({bus.f_rvalid, bus.l_rvalid} !== {prev_f, prev_l}) begin
        n_bad++;
        $display("FAIL arb_rvalid[%0d]: got f/l %b%b expected %b%b", i,
                 bus.f_rvalid, bus.l_rvalid, prev_f, prev_l);
      end
      if (prev_f) begin
        n_cmp++;
        if (bus.f_rdata !== 32'h1000_0003) begin
          n_bad++;
          $display("FAIL arb_f_rdata[%0d]: got %h expected %h", i, bus.f_rdata, 32'h1000_0003);
        end
      end
      prev_l = e;
      prev_f = ~e;
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if ({bus.l_rvalid, bus.l_rdata} !== {1'b1, 32'h1000_0002}) begin
      n_bad++;
      $display("FAIL arb_l_rdata: got %h expected %h", {bus.l_rvalid, bus.l_rdata}, {1'b1, 32'h1000_0002});
    end
    tick();
  endtask

  task automatic test_reset_mid;
    bus.f_req = 1'b1; bus.f_addr = 32'h4;
    #1;
    n_cmp++;
    if ({bus.f_gnt, bus.mem_a} !== {1'b1, 32'h4}) begin
      n_bad++;
      $display("FAIL rst_mid_pre_gnt: got %h expected %h", {bus.f_gnt, bus.mem_a}, {1'b1, 32'h4});
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus.f_gnt, bus.f_rvalid, bus.f_rdata, bus.mem_a} !== 66'h0) begin
      n_bad++;
      $display("FAIL rst_mid_hold: got %h expected %h",
               {bus.f_gnt, bus.f_rvalid, bus.f_rdata, bus.mem_a}, 66'h0);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if ({bus.f_gnt, bus.f_rvalid, bus.mem_a} !== {1'b1, 1'b0, 32'h4}) begin
      n_bad++;
      $display("FAIL rst_mid_regrant: got %h expected %h",
               {bus.f_gnt, bus.f_rvalid, bus.mem_a}, {1'b1, 1'b0, 32'h4});
    end
    tick();
    bus.f_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.f_rvalid, bus.f_rdata} !== {1'b1, 32'h1000_0001}) begin
      n_bad++;
      $display("FAIL rst_mid_resp: got %h expected %h", {bus.f_rvalid, bus.f_rdata}, {1'b1, 32'h1000_0001});
    end
    tick();
  endtask

  task automatic test_withdraw;
    bus.f_req = 1'b1; bus.f_addr = 32'h10;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h30; bus.l_wdata = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++;
      if ({bus.f_gnt, bus.l_gnt, bus.mem_we} !== 3'b100) begin
        n_bad++;
        $display("FAIL wd_pending[%0d]: got %b expected 100", i, {bus.f_gnt, bus.l_gnt, bus.mem_we});
      end
      tick();
    end
    bus.l_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.f_gnt, bus.l_gnt, bus.mem_we, bus.l_rvalid} !== 4'b1000) begin
      n_bad++;
      $display("FAIL wd_dropped: got %b expected 1000", {bus.f_gnt, bus.l_gnt, bus.mem_we, bus.l_rvalid});
    end
    tick();
    bus.l_req = 1'b1; bus.l_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({bus.f_gnt, bus.l_gnt, bus.l_rvalid} !== {i != 4, i == 4, 1'b0}) begin
        n_bad++;
        $display("FAIL wd_reraise[%0d]: got %b expected %b", i,
                 {bus.f_gnt, bus.l_gnt, bus.l_rvalid}, {i != 4, i == 4, 1'b0});
      end
      tick();
    end
    idle();
    #1;
    n_cmp++;
    if ({bus.l_rvalid, bus.l_rdata} !== {1'b1, 32'h1000_000C}) begin
      n_bad++;
      $display("FAIL wd_mem_intact: got %h expected %h", {bus.l_rvalid, bus.l_rdata}, {1'b1, 32'h1000_000C});
    end
    tick();
  endtask

`ifdef IMEM_BOUNDS_CHECK_EN
  task automatic test_bounds;
    bus.l_req = 1'b1; bus.l_we = 1'b1; bus.l_addr = 32'h100; bus.l_wdata = 32'h1234_5678;
    #1;
    n_cmp++;
    if ({bus.l_gnt, bus.mem_we} !== 2'b10) begin
      n_bad++;
      $display("FAIL bnd_l_gnt_we: got %b expected 10", {bus.l_gnt, bus.mem_we});
    end
    tick();
    bus.l_req = 1'b0; bus.l_we = 1'b0;
    bus.f_req = 1'b1; bus.f_addr = 32'h6;
    #1;
    n_cmp++;
    if ({bus.l_rvalid, bus.l_rdata, bus.l_err} !== {1'b1, 32'hDEAD_BEEF, 1'b1}) begin
      n_bad++;
      $display("FAIL bnd_l_resp: got %h expected %h",
               {bus.l_rvalid, bus.l_rdata, bus.l_err}, {1'b1, 32'hDEAD_BEEF, 1'b1});
    end
    n_cmp++;
    if ({bus.f_gnt, bus.mem_we, bus.mem_a} !== {1'b1, 1'b0, 32'h4}) begin
      n_bad++;
      $display("FAIL bnd_f_gnt: got %h expected %h", {bus.f_gnt, bus.mem_we, bus.mem_a}, {1'b1, 1'b0, 32'h4});
    end
    tick();
    bus.f_req = 1'b0;
    #1;
    n_cmp++;
    if ({bus.f_rvalid, bus.f_rdata, bus.f_err, bus.l_err} !== {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL bnd_f_resp: got %h expected %h",
               {bus.f_rvalid, bus.f_rdata, bus.f_err, bus.l_err}, {1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0});
    end
    tick();
  endtask
`endif

  initial begin
    bus.f_addr  = '0;
    bus.l_addr  = '0;
    bus.l_wdata = '0;
    idle();
    #1 rst_n = 1'b0;
    test_reset();
    test_f_stream();
    test_l_write_read();
    test_arbitration();
    test_reset_mid();
    test_withdraw();
`ifdef IMEM_BOUNDS_CHECK_EN
    test_bounds();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
